cpu_control: RTL

//   Mini-CPU control sequencer: drives stateCPU, opcode, addr1..3 and valorGuardarRAM into the RAM bank.

---
 rtl/cpu_control_if.sv | 34 +++
 rtl/cpu_control.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_if.sv
// Bundle of the instruction handshake, the RAM bank side and the user-facing
// result signals of the mini-CPU control sequencer.
interface cpu_control_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        read;
  logic        stored;
  logic [15:0] v1RAM;
  logic [15:0] v2RAM;
  logic [2:0]  stateCPU;
  logic [2:0]  opcode;
  logic [3:0]  addr1;
  logic [3:0]  addr2;
  logic [3:0]  addr3;
  logic [15:0] valorGuardarRAM;
  logic [15:0] display_value;
  logic        display_valid;
  logic        error;

  // sequencer side
  modport master (
    input  instr_valid, instr, read, stored, v1RAM, v2RAM,
    output instr_ready, stateCPU, opcode, addr1, addr2, addr3,
           valorGuardarRAM, display_value, display_valid, error
  );

  // instruction source / RAM bank side
  modport slave (
    output instr_valid, instr, read, stored, v1RAM, v2RAM,
    input  instr_ready, stateCPU, opcode, addr1, addr2, addr3,
           valorGuardarRAM, display_value, display_valid, error
  );
endinterface

// File: rtl/cpu_control.sv
// Mini-CPU control sequencer: fetches one 16-bit instruction, reads operands
// from the RAM bank, computes the result, stores it back and shows it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// OFF     | powered down, waiting for power_on
// FETCH   | instr_ready high, latch instruction on instr_valid
// DECODE  | opcode/addresses on the bus, pick READ or straight to CALC
// READ    | wait for read ack, capture v1RAM/v2RAM (bounded by timer)
// CALC    | compute result
// STORE   | present result to RAM, wait for stored ack (bounded)
// DISPLAY | one-cycle display_valid pulse, back to FETCH
module cpu_control #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          power_on,
  cpu_control_if.master bus
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_READ    = 3'b011,
    ST_CALC    = 3'b100,
    ST_DISPLAY = 3'b101,
    ST_STORE   = 3'b110
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_ADDI  = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_SUBI  = 3'd4;
  localparam logic [2:0] OP_MUL   = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;
  localparam logic [2:0] OP_DISP  = 3'd7;

  // Down-counter: loaded with ACK_TIMEOUT-1 on entry, timeout when it is 0
  // and still no ack, so the wait lasts exactly ACK_TIMEOUT cycles.
  localparam int          TW       = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMR_LOAD = TW'(ACK_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [2:0]    opcode_q, opcode_d;
  logic [3:0]    addr1_q, addr1_d;
  logic [3:0]    addr2_q, addr2_d;
  logic [3:0]    addr3_q, addr3_d;
  logic [6:0]    imm_q, imm_d;
  logic [15:0]   v1_q, v1_d;
  logic [15:0]   v2_q, v2_d;
  logic [15:0]   valor_q, valor_d;
  logic [15:0]   disp_q, disp_d;
  logic          error_q, error_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [15:0]   imm7;
  logic [15:0]   imm5;
  logic [15:0]   mul_lo;
  logic [15:0]   alu_res;

  // ALU: result of the latched instruction, mod 2^16
  always_comb begin
    imm7    = {{9{imm_q[6]}}, imm_q};
    imm5    = {{11{imm_q[4]}}, imm_q[4:0]};
    mul_lo  = v1_q * imm5;
    alu_res = '0;
    case (opcode_q)
      OP_LOAD:  alu_res = imm7;
      OP_ADD:   alu_res = v1_q + v2_q;
      OP_ADDI:  alu_res = v1_q + imm5;
      OP_SUB:   alu_res = v1_q - v2_q;
      OP_SUBI:  alu_res = v1_q - imm5;
      OP_MUL:   alu_res = mul_lo;
      OP_CLEAR: alu_res = '0;
      default:  alu_res = v1_q;
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    addr3_d  = addr3_q;
    imm_d    = imm_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    valor_d  = valor_q;
    disp_d   = disp_q;
    error_d  = error_q;
    timer_d  = timer_q;

    if (!power_on) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_FETCH;
        ST_FETCH: begin
          if (bus.instr_valid) begin
            opcode_d = bus.instr[15:13];
            imm_d    = bus.instr[6:0];
            error_d  = 1'b0;
            addr1_d  = '0;
            addr2_d  = '0;
            addr3_d  = '0;
            case (bus.instr[15:13])
              OP_LOAD, OP_DISP: addr1_d = bus.instr[12:9];
              OP_ADD, OP_SUB: begin
                addr1_d = bus.instr[8:5];
                addr2_d = bus.instr[4:1];
                addr3_d = bus.instr[12:9];
              end
              OP_ADDI, OP_SUBI, OP_MUL: begin
                addr1_d = bus.instr[8:5];
                addr2_d = bus.instr[12:9];
              end
              default: ;
            endcase
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          timer_d = TMR_LOAD;
          state_d = (opcode_q == OP_LOAD || opcode_q == OP_CLEAR) ? ST_CALC : ST_READ;
        end
        ST_READ: begin
          if (bus.read) begin
            v1_d    = bus.v1RAM;
            v2_d    = bus.v2RAM;
            state_d = ST_CALC;
          end else if (timer_q == '0) begin
            error_d = 1'b1;
            state_d = ST_FETCH;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        ST_CALC: begin
          if (opcode_q == OP_DISP) begin
            disp_d  = alu_res;
            state_d = ST_DISPLAY;
          end else begin
            valor_d = alu_res;
            timer_d = TMR_LOAD;
            state_d = ST_STORE;
          end
        end
        ST_STORE: begin
          if (bus.stored) begin
            disp_d  = valor_q;
            state_d = ST_DISPLAY;
          end else if (timer_q == '0) begin
            error_d = 1'b1;
            state_d = ST_FETCH;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        ST_DISPLAY: state_d = ST_FETCH;
        default:    state_d = ST_OFF;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      opcode_q <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      addr3_q  <= '0;
      imm_q    <= '0;
      v1_q     <= '0;
      v2_q     <= '0;
      valor_q  <= '0;
      disp_q   <= '0;
      error_q  <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      addr3_q  <= addr3_d;
      imm_q    <= imm_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      valor_q  <= valor_d;
      disp_q   <= disp_d;
      error_q  <= error_d;
      timer_q  <= timer_d;
    end
  end

  // display_value is written on entry to DISPLAY so it lines up with the pulse
  assign bus.instr_ready     = (state_q == ST_FETCH);
  assign bus.stateCPU        = state_q;
  assign bus.opcode          = opcode_q;
  assign bus.addr1           = addr1_q;
  assign bus.addr2           = addr2_q;
  assign bus.addr3           = addr3_q;
  assign bus.valorGuardarRAM = valor_q;
  assign bus.display_value   = disp_q;
  assign bus.display_valid   = (state_q == ST_DISPLAY);
  assign bus.error           = error_q;

endmodule
